// File: rtl/frame_memory_arbiter_pkg.sv
// Shared types and constants for the triple-buffered video pipeline:
// arbiter states, data-path owner encoding and the frame-buffer count.
package frame_memory_arbiter_pkg;

  localparam int NUM_BUFFERS     = 3;
  localparam int BUFFER_ID_WIDTH = 2;
  localparam int STREAK_WIDTH    = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_BURST,
    ST_RELEASE
  } arb_state_t;

  typedef enum logic {
    OWNER_WRITE = 1'b0,
    OWNER_READ  = 1'b1
  } owner_t;

  function automatic logic buffer_id_valid(input logic [BUFFER_ID_WIDTH-1:0] id,
                                           input int num_buffers);
    return (int'(id) < num_buffers);
  endfunction

endpackage

// File: rtl/frame_memory_arbiter_fairness_counter.sv
// Counts consecutive read grants taken while a write is waiting and raises
// force_write once the reader has had its allowed streak.
module arb_fairness_counter #(
  parameter int MAX_RD_STREAK = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_grant,
  input  logic wr_grant,
  input  logic wr_req,
  output logic force_write
);
  import frame_memory_arbiter_pkg::*;

  logic [STREAK_WIDTH-1:0] streak;

  // A read grant with no writer waiting breaks the streak.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (wr_grant) begin
      streak <= '0;
    end else if (rd_grant) begin
      if (!wr_req) begin
        streak <= '0;
      end else if (streak != {STREAK_WIDTH{1'b1}}) begin
        streak <= streak + 1'b1;
      end
    end
  end

  assign force_write = (streak == STREAK_WIDTH'(MAX_RD_STREAK));

endmodule

// File: rtl/frame_memory_arbiter.sv
// Frame-memory command arbiter: one burst at a time on the shared command port,
// read-preferred so the display never starves, with bounded write fairness.
module frame_memory_arbiter #(
  parameter int OFFSET_WIDTH  = 19,
  parameter int ADDR_WIDTH    = OFFSET_WIDTH + 2,
  parameter int NUM_BUFFERS   = frame_memory_arbiter_pkg::NUM_BUFFERS,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    mem_init_done,
  input  logic                    wr_req,
  input  logic [1:0]              wr_buffer_id,
  input  logic [OFFSET_WIDTH-1:0] wr_offset,
  output logic                    wr_grant,
  output logic                    wr_done,
  input  logic                    rd_req,
  input  logic [1:0]              rd_buffer_id,
  input  logic [OFFSET_WIDTH-1:0] rd_offset,
  output logic                    rd_grant,
  output logic                    rd_done,
  output logic                    mem_cmd_valid,
  output logic                    mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
  input  logic                    mem_cmd_ready,
  input  logic                    mem_burst_done,
  output logic                    mem_owner,
  output logic                    proto_err
);
  import frame_memory_arbiter_pkg::*;

  arb_state_t              state;
  arb_state_t              state_next;
  owner_t                  owner_q;
  logic                    skip_q;
  logic                    force_write;
  logic                    pick_write;
  logic                    win_ok;
  logic                    arb_win;
  logic                    accept;
  logic [1:0]              win_id;
  logic [OFFSET_WIDTH-1:0] win_offset;

  arb_fairness_counter #(
    .MAX_RD_STREAK(MAX_RD_STREAK)
  ) u_fairness (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_grant   (rd_grant),
    .wr_grant   (wr_grant),
    .wr_req     (wr_req),
    .force_write(force_write)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_next;
  end

  // An invalid buffer index skips ISSUE and walks BURST->RELEASE on its own.
  always_comb begin
    pick_write = wr_req && (!rd_req || force_write);
    win_id     = pick_write ? wr_buffer_id : rd_buffer_id;
    win_offset = pick_write ? wr_offset : rd_offset;
    win_ok     = buffer_id_valid(win_id, NUM_BUFFERS);
    arb_win    = 1'b0;
    accept     = 1'b0;
    state_next = state;
    case (state)
      ST_INIT: begin
        if (mem_init_done) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          arb_win    = 1'b1;
          state_next = win_ok ? ST_ISSUE : ST_BURST;
        end
      end
      ST_ISSUE: begin
        if (mem_cmd_ready) begin
          accept     = 1'b1;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (skip_q || mem_burst_done) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_cmd_valid <= 1'b0;
      mem_cmd_write <= 1'b0;
      mem_cmd_addr  <= '0;
      wr_grant      <= 1'b0;
      rd_grant      <= 1'b0;
      wr_done       <= 1'b0;
      rd_done       <= 1'b0;
      owner_q       <= OWNER_WRITE;
      skip_q        <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      if (arb_win) begin
        owner_q       <= pick_write ? OWNER_WRITE : OWNER_READ;
        mem_cmd_write <= pick_write;
        mem_cmd_addr  <= ADDR_WIDTH'({win_id, win_offset});
        mem_cmd_valid <= win_ok;
        skip_q        <= !win_ok;
        if (!win_ok) begin
          proto_err <= 1'b1;
          wr_grant  <= pick_write;
          rd_grant  <= !pick_write;
        end
      end
      if (accept) begin
        mem_cmd_valid <= 1'b0;
        wr_grant      <= (owner_q == OWNER_WRITE);
        rd_grant      <= (owner_q == OWNER_READ);
      end
      if (state == ST_BURST && state_next == ST_RELEASE) begin
        wr_done <= (owner_q == OWNER_WRITE);
        rd_done <= (owner_q == OWNER_READ);
      end
      // The data-phase strobe is only meaningful while a burst is in flight.
      if (mem_burst_done && state != ST_BURST) proto_err <= 1'b1;
    end
  end

  assign mem_owner = owner_q;

endmodule
